// File: rtl/tap3_complex_mult_pkg.sv
// -----------------------------------------------------------------------------
// tap3_complex_mult_pkg
// Shared signed fixed-point definitions for the 3-tap complex multiplier and
// the downstream 3-input complex adder.
//   CMUL_QI / CMUL_QF : default integer / fraction bit counts
//   CMUL_WIDTH        : default sample width (QI + QF)
//   cplx_t            : one complex sample in the default format
//   fx_width()        : width derivation used by parameterised modules
//   sat_max/sat_min() : saturation limits for a given width
// -----------------------------------------------------------------------------
package tap3_complex_mult_pkg;

  localparam int CMUL_QI    = 3;
  localparam int CMUL_QF    = 3;
  localparam int CMUL_WIDTH = CMUL_QI + CMUL_QF;

  typedef struct packed {
    logic signed [CMUL_WIDTH-1:0] re;
    logic signed [CMUL_WIDTH-1:0] im;
  } cplx_t;

  function automatic int fx_width(input int qi, input int qf);
    return qi + qf;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/tap3_complex_mult_cmul_rescale.sv
// -----------------------------------------------------------------------------
// cmul_rescale
// One complex tap product, split around the stage-1 register of the parent:
//   front half : h * w partial products (pp_rr, pp_ii, pp_ri, pp_ir), 2*WIDTH
//   back half  : registered partials (pq_*) combined to 2*WIDTH+1 bits,
//                arithmetic shift right by QF (floor), reduced to WIDTH bits
// Ports:
//   h_re/h_im, w_re/w_im : coefficient and window sample (signed WIDTH)
//   pp_*                 : partial products out (signed 2*WIDTH)
//   pq_*                 : registered partial products in (signed 2*WIDTH)
//   y_re/y_im            : rescaled product (signed WIDTH)
//   ovf                  : either component lost significant upper bits
// Build option: CMUL_SAT_EN defined -> overflowing components saturate,
// otherwise they wrap (low WIDTH bits kept).
// -----------------------------------------------------------------------------
module cmul_rescale
  import tap3_complex_mult_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int QF    = 3
) (
  input  logic signed [WIDTH-1:0]   h_re,
  input  logic signed [WIDTH-1:0]   h_im,
  input  logic signed [WIDTH-1:0]   w_re,
  input  logic signed [WIDTH-1:0]   w_im,
  output logic signed [2*WIDTH-1:0] pp_rr,
  output logic signed [2*WIDTH-1:0] pp_ii,
  output logic signed [2*WIDTH-1:0] pp_ri,
  output logic signed [2*WIDTH-1:0] pp_ir,
  input  logic signed [2*WIDTH-1:0] pq_rr,
  input  logic signed [2*WIDTH-1:0] pq_ii,
  input  logic signed [2*WIDTH-1:0] pq_ri,
  input  logic signed [2*WIDTH-1:0] pq_ir,
  output logic signed [WIDTH-1:0]   y_re,
  output logic signed [WIDTH-1:0]   y_im,
  output logic                      ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int FW = 2 * WIDTH + 1;

`ifdef CMUL_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));
`endif

  logic signed [PW-1:0] hr_x, hi_x, wr_x, wi_x;
  logic signed [FW-1:0] full_re, full_im, sh_re, sh_im;
  logic                 ovf_re, ovf_im;

  always_comb begin
    hr_x  = PW'(h_re);
    hi_x  = PW'(h_im);
    wr_x  = PW'(w_re);
    wi_x  = PW'(w_im);
    // A WIDTH x WIDTH signed product always fits in 2*WIDTH bits.
    pp_rr = hr_x * wr_x;
    pp_ii = hi_x * wi_x;
    pp_ri = hr_x * wi_x;
    pp_ir = hi_x * wr_x;
  end

  always_comb begin
    full_re = FW'(pq_rr) - FW'(pq_ii);
    full_im = FW'(pq_ri) + FW'(pq_ir);
    sh_re   = full_re >>> QF;
    sh_im   = full_im >>> QF;
    // Result is valid only if every discarded bit equals the new sign bit.
    ovf_re  = !((&sh_re[FW-1:WIDTH-1]) || !(|sh_re[FW-1:WIDTH-1]));
    ovf_im  = !((&sh_im[FW-1:WIDTH-1]) || !(|sh_im[FW-1:WIDTH-1]));
    ovf     = ovf_re | ovf_im;
`ifdef CMUL_SAT_EN
    y_re    = ovf_re ? (sh_re[FW-1] ? SAT_LO : SAT_HI) : sh_re[WIDTH-1:0];
    y_im    = ovf_im ? (sh_im[FW-1] ? SAT_LO : SAT_HI) : sh_im[WIDTH-1:0];
`else
    y_re    = sh_re[WIDTH-1:0];
    y_im    = sh_im[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/tap3_complex_mult.sv
// -----------------------------------------------------------------------------
// tap3_complex_mult
// Three-tap complex multiplier: keeps a sample window w0..w2 and produces
// pk = hk * wk for k = 0..2 in signed Q(QI.QF), feeding a 3-input adder.
// Two pipeline stages: stage 1 holds the window and the partial products,
// stage 2 holds the rescaled products, out_valid and overflow.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid/in_ready       : sample handshake, x_Re/x_Im sample
//   flush                   : clears window, fill count and pipeline valids
//   coef_we/coef_sel/coef_* : coefficient write (coef_sel 3 is ignored)
//   p0..p2 _Re/_Im          : tap products
//   out_valid/out_ready     : product handshake
//   overflow                : any product component overflowed
// Build option: CMUL_SAT_EN (saturate instead of wrap on overflow).
// -----------------------------------------------------------------------------
module tap3_complex_mult
  import tap3_complex_mult_pkg::*;
#(
  parameter  int QI    = CMUL_QI,
  parameter  int QF    = CMUL_QF,
  localparam int WIDTH = fx_width(QI, QF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_Re,
  input  logic signed [WIDTH-1:0] x_Im,
  input  logic                    flush,
  input  logic                    coef_we,
  input  logic [1:0]              coef_sel,
  input  logic signed [WIDTH-1:0] coef_Re,
  input  logic signed [WIDTH-1:0] coef_Im,
  output logic signed [WIDTH-1:0] p0_Re,
  output logic signed [WIDTH-1:0] p0_Im,
  output logic signed [WIDTH-1:0] p1_Re,
  output logic signed [WIDTH-1:0] p1_Im,
  output logic signed [WIDTH-1:0] p2_Re,
  output logic signed [WIDTH-1:0] p2_Im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int PW   = 2 * WIDTH;
  localparam int NTAP = 3;

  logic signed [WIDTH-1:0] h_re_q [NTAP], h_re_d [NTAP];
  logic signed [WIDTH-1:0] h_im_q [NTAP], h_im_d [NTAP];
  logic signed [WIDTH-1:0] w_re_q [NTAP], w_re_d [NTAP];
  logic signed [WIDTH-1:0] w_im_q [NTAP], w_im_d [NTAP];
  logic signed [PW-1:0]    rr_q [NTAP], rr_d [NTAP];
  logic signed [PW-1:0]    ii_q [NTAP], ii_d [NTAP];
  logic signed [PW-1:0]    ri_q [NTAP], ri_d [NTAP];
  logic signed [PW-1:0]    ir_q [NTAP], ir_d [NTAP];
  logic signed [WIDTH-1:0] p_re_q [NTAP], p_re_d [NTAP];
  logic signed [WIDTH-1:0] p_im_q [NTAP], p_im_d [NTAP];
  logic [1:0]              fill_q, fill_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;

  // Combinational tap signals: multiplier inputs take the window as it will
  // be after this sample shifts in, so stage 1 captures matching partials.
  logic signed [WIDTH-1:0] mul_w_re [NTAP], mul_w_im [NTAP];
  logic signed [PW-1:0]    pp_rr [NTAP], pp_ii [NTAP], pp_ri [NTAP], pp_ir [NTAP];
  logic signed [WIDTH-1:0] y_re [NTAP], y_im [NTAP];
  logic [NTAP-1:0]         y_ovf;

  logic accept;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NTAP; k++) begin : g_tap
    if (k == 0) begin : g_first
      assign mul_w_re[k] = x_Re;
      assign mul_w_im[k] = x_Im;
    end else begin : g_rest
      assign mul_w_re[k] = w_re_q[k-1];
      assign mul_w_im[k] = w_im_q[k-1];
    end

    cmul_rescale #(
      .WIDTH (WIDTH),
      .QF    (QF)
    ) u_cmul (
      .h_re  (h_re_q[k]),
      .h_im  (h_im_q[k]),
      .w_re  (mul_w_re[k]),
      .w_im  (mul_w_im[k]),
      .pp_rr (pp_rr[k]),
      .pp_ii (pp_ii[k]),
      .pp_ri (pp_ri[k]),
      .pp_ir (pp_ir[k]),
      .pq_rr (rr_q[k]),
      .pq_ii (ii_q[k]),
      .pq_ri (ri_q[k]),
      .pq_ir (ir_q[k]),
      .y_re  (y_re[k]),
      .y_im  (y_im[k]),
      .ovf   (y_ovf[k])
    );
  end

  always_comb begin
    h_re_d      = h_re_q;
    h_im_d      = h_im_q;
    w_re_d      = w_re_q;
    w_im_d      = w_im_q;
    rr_d        = rr_q;
    ii_d        = ii_q;
    ri_d        = ri_q;
    ir_d        = ir_q;
    p_re_d      = p_re_q;
    p_im_d      = p_im_q;
    fill_d      = fill_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;

    // Coefficient writes are independent of stalls and flushes; in-flight
    // partials were already captured with the previous value.
    for (int k = 0; k < NTAP; k++) begin
      if (coef_we && (coef_sel == 2'(k))) begin
        h_re_d[k] = coef_Re;
        h_im_d[k] = coef_Im;
      end
    end

    if (flush) begin
      // Flush wins over a same-cycle accepted sample, which is dropped.
      for (int k = 0; k < NTAP; k++) begin
        w_re_d[k] = '0;
        w_im_d[k] = '0;
      end
      fill_d      = 2'd0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (in_ready) begin
      if (accept) begin
        w_re_d[0] = x_Re;
        w_im_d[0] = x_Im;
        w_re_d[1] = w_re_q[0];
        w_im_d[1] = w_im_q[0];
        w_re_d[2] = w_re_q[1];
        w_im_d[2] = w_im_q[1];
        rr_d      = pp_rr;
        ii_d      = pp_ii;
        ri_d      = pp_ri;
        ir_d      = pp_ir;
        fill_d    = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
      end
      // Only a sample that completes a full window produces an output.
      s1_valid_d  = accept && (fill_q >= 2'd2);
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        p_re_d = y_re;
        p_im_d = y_im;
        ovf_d  = |y_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) begin
        h_re_q[k] <= '0;
        h_im_q[k] <= '0;
        w_re_q[k] <= '0;
        w_im_q[k] <= '0;
        rr_q[k]   <= '0;
        ii_q[k]   <= '0;
        ri_q[k]   <= '0;
        ir_q[k]   <= '0;
        p_re_q[k] <= '0;
        p_im_q[k] <= '0;
      end
      fill_q      <= 2'd0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      h_re_q      <= h_re_d;
      h_im_q      <= h_im_d;
      w_re_q      <= w_re_d;
      w_im_q      <= w_im_d;
      rr_q        <= rr_d;
      ii_q        <= ii_d;
      ri_q        <= ri_d;
      ir_q        <= ir_d;
      p_re_q      <= p_re_d;
      p_im_q      <= p_im_d;
      fill_q      <= fill_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign p0_Re     = p_re_q[0];
  assign p0_Im     = p_im_q[0];
  assign p1_Re     = p_re_q[1];
  assign p1_Im     = p_im_q[1];
  assign p2_Re     = p_re_q[2];
  assign p2_Im     = p_im_q[2];
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tap3_complex_mult.sv
// Directed bench for tap3_complex_mult in the default Q3.3 format
// (WIDTH 6, 1.0 = 8). Inputs change and outputs are sampled 1 time unit
// after the rising clock edge.
module tb_tap3_complex_mult;

  localparam int W = 6;
`ifdef CMUL_SAT_EN
  localparam int OVF_P0 = 31;
`else
  localparam int OVF_P0 = -16;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] x_Re = '0;
  logic signed [W-1:0] x_Im = '0;
  logic                flush = 1'b0;
  logic                coef_we = 1'b0;
  logic [1:0]          coef_sel = 2'd0;
  logic signed [W-1:0] coef_Re = '0;
  logic signed [W-1:0] coef_Im = '0;
  logic signed [W-1:0] p0_Re, p0_Im, p1_Re, p1_Im, p2_Re, p2_Im;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                overflow;

  int vectors = 0;
  int miscompares = 0;

  tap3_complex_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_Re      (x_Re),
    .x_Im      (x_Im),
    .flush     (flush),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_Re   (coef_Re),
    .coef_Im   (coef_Im),
    .p0_Re     (p0_Re),
    .p0_Im     (p0_Im),
    .p1_Re     (p1_Re),
    .p1_Im     (p1_Im),
    .p2_Re     (p2_Re),
    .p2_Im     (p2_Im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int sel, input int re, input int im);
    coef_we  = 1'b1;
    coef_sel = 2'(sel);
    coef_Re  = W'(re);
    coef_Im  = W'(im);
    tick();
    coef_we  = 1'b0;
  endtask

  task automatic send(input int re, input int im);
    in_valid = 1'b1;
    x_Re     = W'(re);
    x_Im     = W'(im);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p0re"}, int'(p0_Re), 0);
    chk({tag, "_p0im"}, int'(p0_Im), 0);
    chk({tag, "_p1re"}, int'(p1_Re), 0);
    chk({tag, "_p1im"}, int'(p1_Im), 0);
    chk({tag, "_p2re"}, int'(p2_Re), 0);
    chk({tag, "_p2im"}, int'(p2_Im), 0);
    chk({tag, "_ovalid"}, int'(out_valid), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_inrdy"}, int'(in_ready), 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // All three taps = 1.0; samples 1.0, 2.0, 3.0
    set_coef(0, 8, 0);
    set_coef(1, 8, 0);
    set_coef(2, 8, 0);
    set_coef(3, 5, 5);          // ignored select
    in_valid = 1'b1;
    x_Re = 6'sd8;  x_Im = '0; tick();
    x_Re = 6'sd16;            tick();
    x_Re = 6'sd24;            tick();
    in_valid = 1'b0;
    chk("fill_one_cycle_ovalid", int'(out_valid), 0);
    tick();
    chk("fill_ovalid", int'(out_valid), 1);
    chk("fill_p0", int'(p0_Re), 24);
    chk("fill_p1", int'(p1_Re), 16);
    chk("fill_p2", int'(p2_Re), 8);
    chk("fill_p0im", int'(p0_Im), 0);
    chk("fill_ovf", int'(overflow), 0);
    tick();
    chk("fill_single_pulse", int'(out_valid), 0);
    chk("fill_hold_p0", int'(p0_Re), 24);

    // j rotation: h0 = j, x = 1.0 -> p0 = j; window was 24,16,8
    set_coef(0, 0, 8);
    send(8, 0);
    tick();
    chk("rot_ovalid", int'(out_valid), 1);
    chk("rot_p0re", int'(p0_Re), 0);
    chk("rot_p0im", int'(p0_Im), 8);
    chk("rot_p1re", int'(p1_Re), 24);
    chk("rot_p2re", int'(p2_Re), 16);

    // Overflow: 2.0 * 3.0 = 6.0 does not fit Q3.3; window 8,24,16
    set_coef(0, 16, 0);
    send(24, 0);
    tick();
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_p0re", int'(p0_Re), OVF_P0);
    chk("ovf_p0im", int'(p0_Im), 0);
    chk("ovf_p1re", int'(p1_Re), 8);
    chk("ovf_p2re", int'(p2_Re), 24);

    // Floor truncation; window 24,8,24
    set_coef(0, 1, 0);
    send(1, 0);
    tick();
    chk("trunc_pos_p0re", int'(p0_Re), 0);
    chk("trunc_pos_p1re", int'(p1_Re), 24);
    chk("trunc_pos_ovf", int'(overflow), 0);
    set_coef(0, -1, 0);
    send(1, 0);
    tick();
    chk("trunc_neg_p0re", int'(p0_Re), -1);
    chk("trunc_neg_p0im", int'(p0_Im), 0);

    // Backpressure; all taps 1.0, window 1,1,24
    set_coef(0, 8, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_Re = 6'sd5; x_Im = '0; tick();
    x_Re = 6'sd6;            tick();
    x_Re = 6'sd7;
    chk("bp_ovalid", int'(out_valid), 1);
    chk("bp_p0", int'(p0_Re), 5);
    chk("bp_p1", int'(p1_Re), 1);
    chk("bp_p2", int'(p2_Re), 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_inrdy_low", int'(in_ready), 0);
      tick();
      chk("bp_held_valid", int'(out_valid), 1);
      chk("bp_held_p0", int'(p0_Re), 5);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_next_p0", int'(p0_Re), 6);
    chk("bp_next_p1", int'(p1_Re), 5);
    chk("bp_next_p2", int'(p2_Re), 1);
    tick();
    chk("bp_last_ovalid", int'(out_valid), 1);
    chk("bp_last_p0", int'(p0_Re), 7);
    chk("bp_last_p1", int'(p1_Re), 6);
    chk("bp_last_p2", int'(p2_Re), 5);
    tick();
    chk("bp_drained", int'(out_valid), 0);

    // Flush with a simultaneous sample, which must be dropped
    flush    = 1'b1;
    in_valid = 1'b1;
    x_Re     = 6'sd20;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_ovalid", int'(out_valid), 0);
    send(2, 0);
    send(3, 0);
    tick();
    chk("flush_refill2_ovalid", int'(out_valid), 0);
    send(4, 0);
    tick();
    chk("flush_refill3_ovalid", int'(out_valid), 1);
    chk("flush_p0", int'(p0_Re), 4);
    chk("flush_p1", int'(p1_Re), 3);
    chk("flush_p2", int'(p2_Re), 2);

    // Reset mid-stream clears everything without a clock edge
    send(9, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    rst = 1'b0;

    // Coefficients were cleared by reset: a full window now yields zero
    in_valid = 1'b1;
    x_Re = 6'sd8; x_Im = 6'sd8;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    chk("postrst_ovalid", int'(out_valid), 1);
    chk("postrst_p0re", int'(p0_Re), 0);
    chk("postrst_p1im", int'(p1_Im), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
